truth_table_sequencer: RTL
==========================

// Module: truth_table_sequencer
// PURPOSE
//  Self-test controller for the 2-input basic-gate unit (AND/OR/NOT-A/NAND/NOR/XOR/XNOR).
//  On start it sweeps inputs (a,b) through 00,01,10,11 and waits a settle time per row.
//  It then samples the seven gate outputs and compares them with internally computed expected values.
//  Reports per-row results, a sticky per-gate failure vector, the first failing row and an overall pass flag.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles between driving gate_a/gate_b and sampling obs; legal range 1..15
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  start       in   1  begin sweep; sampled only in IDLE
//  abort       in   1  synchronous abort of a running sweep
//  gate_a      out  1  drive to gate unit input a (registered)
//  gate_b      out  1  drive to gate unit input b (registered)
//  obs         in   7  gate unit outputs {xnor,xor,nor,nand,not,or,and}, bit0=and
//  busy        out  1  high in SETTLE/CHECK
//  row_valid   out  1  one-cycle strobe; row_idx/row_err valid
//  row_idx     out  2  row just checked = {a,b}
//  row_err     out  7  obs ^ expected for that row
//  fail_vec    out  7  sticky OR of row_err across current sweep
//  first_fail  out  3  {valid,row[1:0]} of first row with nonzero row_err
//  done        out  1  one-cycle strobe at end of a completed sweep
//  pass        out  1  1 if last completed sweep had fail_vec==0; held until next start
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; all outputs 0; internal row=0, cnt=0.
//  FSM states: IDLE, SETTLE, CHECK, DONE.
//  IDLE:
//   - start=1 -> row=0, {gate_a,gate_b}=00, cnt=0, fail_vec=0, first_fail=0, pass=0 -> SETTLE.
//   - start=0 -> stay; all outputs hold.
//  SETTLE:
//   - cnt increments each cycle.
//   - cnt==SETTLE_CYCLES-1 -> CHECK.
//  CHECK (one cycle):
//   - exp = {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b} using current gate_a/gate_b.
//   - row_err=obs^exp; row_idx=row; row_valid=1 next cycle (registered, one cycle).
//   - fail_vec|=row_err.
//   - if first_fail[2]==0 and row_err!=0 then first_fail={1,row}.
//   - if row==3 -> DONE; else row=row+1, {gate_a,gate_b}=row+1, cnt=0 -> SETTLE.
//  DONE (one cycle):
//   - done=1; pass=(fail_vec==0); gate_a/gate_b return to 0 -> IDLE.
//  Latency: start sampled at edge N -> done high during cycle N+1+4*(SETTLE_CYCLES+1).
//   - e.g. SETTLE_CYCLES=2: done in cycle N+13.
//  row_valid pulses exactly 4 times per completed sweep, rows in order 0,1,2,3.
//  Row counter never wraps: sweep ends after row 3.
//  start while busy/DONE: ignored.
//  abort=1 in SETTLE or CHECK:
//   - next state IDLE; gate_a/gate_b=0; no done, no row_valid that cycle.
//   - pass=0; fail_vec/first_fail hold partial values.
//  abort and start together in IDLE: abort wins; stay IDLE.
//  rst_n low mid-sweep: immediate return to reset values; no done.
//  obs is sampled only in CHECK; obs changes in other states are ignored.
// TESTING
//  1. Reset with obs from a correct gate unit, SETTLE=2, pulse start -> rows 0..3 strobe, row_err=0 each, done at cycle+13, pass=1, fail_vec=0.
//  2. obs bit3 (nand) stuck at 0 -> row_err=7'h08 on rows 0,1,2; fail_vec=7'h08, first_fail=3'b100, pass=0.
//  3. obs xor bit forced to 1 only when a=b=1 -> only row 3 err=7'h20; first_fail=3'b111.
//  4. abort asserted in row 1 SETTLE -> IDLE next cycle, gates=00, no done, pass=0; a fresh start gives a clean full sweep.
//  5. rst_n low during CHECK of row 2 -> all outputs 0 asynchronously; start repeated during busy is ignored (exactly 4 row_valid).
//  6. SETTLE_CYCLES=1 build -> done at start+9; obs glitch outside CHECK does not set fail_vec.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - self-test sweep of a 2-input basic-gate unit
// Drives (a,b) through 00..11, samples the seven gate outputs after a settle time and reports mismatches.
module truth_table_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       gate_a,
   output logic       gate_b,
   input  logic [6:0] obs,
   output logic       busy,
   output logic       row_valid,
   output logic [1:0] row_idx,
   output logic [6:0] row_err,
   output logic [6:0] fail_vec,
   output logic [2:0] first_fail,
   output logic       done,
   output logic       pass
);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] row;
   logic [3:0] cnt;
   logic [6:0] exp_obs;
   logic [6:0] err;

   // Bit order matches obs: {xnor, xor, nor, nand, not_a, or, and}.
   assign exp_obs = {~(gate_a ^ gate_b), gate_a ^ gate_b, ~(gate_a | gate_b),
                     ~(gate_a & gate_b), ~gate_a, gate_a | gate_b, gate_a & gate_b};
   assign err     = obs ^ exp_obs;
   assign busy    = (state == SETTLE) || (state == CHECK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start && !abort) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (abort)                 state_nxt = IDLE;
            else if (cnt == CNT_LAST)  state_nxt = CHECK;
         end
         CHECK: begin
            if (abort)                 state_nxt = IDLE;
            else if (row == 2'd3)      state_nxt = DONE;
            else                       state_nxt = SETTLE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_a     <= 1'b0;
         gate_b     <= 1'b0;
         row        <= 2'd0;
         cnt        <= 4'd0;
         row_valid  <= 1'b0;
         row_idx    <= 2'd0;
         row_err    <= 7'd0;
         fail_vec   <= 7'd0;
         first_fail <= 3'd0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else begin
         row_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  row        <= 2'd0;
                  gate_a     <= 1'b0;
                  gate_b     <= 1'b0;
                  cnt        <= 4'd0;
                  fail_vec   <= 7'd0;
                  first_fail <= 3'd0;
                  pass       <= 1'b0;
               end
            end
            SETTLE: begin
               if (abort) begin
                  gate_a <= 1'b0;
                  gate_b <= 1'b0;
                  pass   <= 1'b0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            CHECK: begin
               if (abort) begin
                  gate_a <= 1'b0;
                  gate_b <= 1'b0;
                  pass   <= 1'b0;
               end else begin
                  row_valid <= 1'b1;
                  row_idx   <= row;
                  row_err   <= err;
                  fail_vec  <= fail_vec | err;
                  if (!first_fail[2] && (err != 7'd0)) first_fail <= {1'b1, row};
                  // Row 3 is the last; the counter stops there instead of wrapping.
                  if (row != 2'd3) begin
                     row              <= row + 2'd1;
                     {gate_a, gate_b} <= row + 2'd1;
                     cnt              <= 4'd0;
                  end
               end
            end
            DONE: begin
               done   <= 1'b1;
               pass   <= (fail_vec == 7'd0);
               gate_a <= 1'b0;
               gate_b <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
